regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
Write-port arbiter and read-select controller for the two-entry 32-bit register file (Input/seti/WR write side, seto1/seto2 read side). Two writeback sources share the single write port under round-robin arbitration with a valid/ready handshake. Issues one registered write per cycle to the register file. Steers the two read selects, and keeps a saturating count of arbitration conflicts for performance monitoring.

Parameters:
DW, 32, data width of register file entries and write data
CW, 8, width of the saturating conflict counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
req0_valid  in  1  requester 0 has a write pending
req0_ready  out  1  requester 0 write accepted this cycle
req0_sel  in  1  requester 0 destination register (0 = reg0, 1 = reg1)
req0_data  in  DW  requester 0 write data
req1_valid  in  1  requester 1 has a write pending
req1_ready  out  1  requester 1 write accepted this cycle
req1_sel  in  1  requester 1 destination register
req1_data  in  DW  requester 1 write data
rd_sel1  in  1  read port 1 register select
rd_sel2  in  1  read port 2 register select
rf_wr  out  1  to register file WR
rf_seti  out  1  to register file seti
rf_input  out  DW  to register file Input
rf_seto1  out  1  to register file seto1
rf_seto2  out  1  to register file seto2
rf_out1  in  DW  from register file Output1
rf_out2  in  DW  from register file Output2
rd_data1  out  DW  read port 1 data to consumer
rd_data2  out  DW  read port 2 data to consumer
conflict_cnt  out  CW  saturating count of cycles with both requests valid

Behaviour:
- Reset (reset low, async): rf_wr=0, rf_seti=0, rf_input=0, conflict_cnt=0, round-robin pointer set so requester 0 wins the first conflict. reqX_ready is combinational and is forced 0 while reset is low.
- Handshake: a transfer occurs on a rising edge when reqX_valid and reqX_ready are both 1. Once valid is raised, the requester holds valid, sel and data stable until the transfer. Ready never depends on anything except the valid inputs and the pointer.
- Arbitration (combinational, same cycle):
  - only one valid: that requester gets ready=1.
  - both valid: the requester not granted most recently wins. The pointer updates only on an actual conflict grant.
  - at most one ready is high per cycle.
- Write issue: on a transfer edge, rf_wr<=1, rf_seti<=sel, rf_input<=data. On a cycle with no transfer, rf_wr<=0 and rf_seti/rf_input hold their values.
- Latency: transfer at edge N; rf_wr high during cycle N..N+1; register file captures at edge N+1; new value visible on rf_outX after edge N+1.
- Throughput: one write per cycle. Back-to-back writes to the same register are applied in grant order.
- Reads:
  - rf_seto1=rd_sel1 and rf_seto2=rd_sel2, purely combinational.
  - rd_dataX=rf_outX unless bypass is enabled (see Optional Feature).
- conflict_cnt: increments by 1 on each edge where req0_valid and req1_valid are both 1. It saturates at 2^CW-1 with no wrap.
- Reset mid-operation: rf_wr drops immediately and any in-flight write is discarded. Requesters must re-present after reset deasserts.

Optional Feature:
- Macro RFARB_BYPASS_EN.
- Defined: while rf_wr=1 and rf_seti==rd_selX, rd_dataX=rf_input (write-to-read forwarding of the pending write). Otherwise rd_dataX=rf_outX.
- Undefined: rd_dataX=rf_outX always. The new value appears only after edge N+1.

Test Plan:
- Reset low mid-run with requests active -> rf_wr=0, rf_input=0, conflict_cnt=0, both readys 0 immediately. After release, first conflict is granted to req0.
- req0_valid=1, sel=1, data=0xDEADBEEF, req1 idle -> req0_ready=1 same cycle. Next cycle rf_wr=1, rf_seti=1, rf_input=0xDEADBEEF. After the following edge, with rd_sel1=1, rd_data1=0xDEADBEEF.
- Both valid for 4 cycles with fresh data each accept (req0 0x1,0x2..; req1 0xA,0xB..) -> grants go req0, req1, req0, req1; rf_input sequence 0x1, 0xA, 0x2, 0xB; conflict_cnt=4.
- CW=2, both valid for 6 cycles -> conflict_cnt goes 1, 2, 3, then stays at 3.
- Same destination sel=0: req0 writes 0x11 then req1 writes 0x22 in consecutive cycles -> reg0 ends at 0x22. rf_wr stays high for 2 cycles, then 0.
- RFARB_BYPASS_EN defined, write 0x55 to reg1 with rd_sel2=1 -> rd_data2=0x55 in the rf_wr cycle. Undefined -> rd_data2 shows the old value that cycle and 0x55 one cycle later.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin write arbiter and read-select steering for a two-entry register file
// Optional write-to-read forwarding of the pending write is enabled by defining RFARB_BYPASS_EN.
module regfile_wr_arbiter #(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_sel,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_sel,
  input  logic [DW-1:0] req1_data,
  input  logic          rd_sel1,
  input  logic          rd_sel2,
  output logic          rf_wr,
  output logic          rf_seti,
  output logic [DW-1:0] rf_input,
  output logic          rf_seto1,
  output logic          rf_seto2,
  input  logic [DW-1:0] rf_out1,
  input  logic [DW-1:0] rf_out2,
  output logic [DW-1:0] rd_data1,
  output logic [DW-1:0] rd_data2,
  output logic [CW-1:0] conflict_cnt
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  // prio = 1 means requester 1 wins the next conflict.
  logic prio;
  logic both;

  assign both = req0_valid & req1_valid;

  always_comb begin
    req0_ready = reset & req0_valid & (~req1_valid | ~prio);
    req1_ready = reset & req1_valid & (~req0_valid | prio);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio         <= 1'b0;
      rf_wr        <= 1'b0;
      rf_seti      <= 1'b0;
      rf_input     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (req0_ready) begin
        rf_wr    <= 1'b1;
        rf_seti  <= req0_sel;
        rf_input <= req0_data;
      end else if (req1_ready) begin
        rf_wr    <= 1'b1;
        rf_seti  <= req1_sel;
        rf_input <= req1_data;
      end else begin
        rf_wr <= 1'b0;
      end
      // Only a contested grant moves the round-robin pointer.
      if (both) begin
        prio <= ~prio;
        if (conflict_cnt != CNT_MAX) conflict_cnt <= conflict_cnt + CNT_ONE;
      end
    end
  end

  assign rf_seto1 = rd_sel1;
  assign rf_seto2 = rd_sel2;

`ifdef RFARB_BYPASS_EN
  assign rd_data1 = (rf_wr && (rf_seti == rd_sel1)) ? rf_input : rf_out1;
  assign rd_data2 = (rf_wr && (rf_seti == rd_sel2)) ? rf_input : rf_out2;
`else
  assign rd_data1 = rf_out1;
  assign rd_data2 = rf_out2;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - self-checking bench for regfile_wr_arbiter with a register file model
module tb_regfile_wr_arbiter;
  localparam int DW = 32;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          v0, r0, s0, v1, r1, s1;
  logic [DW-1:0] d0, d1;
  logic          rd_sel1, rd_sel2;
  logic          rf_wr, rf_seti, seto1, seto2;
  logic [DW-1:0] rf_input, rf_out1, rf_out2, rd_data1, rd_data2;
  logic [CW-1:0] cnt;
  logic          r0_s, r1_s, wr_s, seti_s, seto1_s, seto2_s;
  logic [DW-1:0] input_s, rdd1_s, rdd2_s;
  logic [1:0]    cnt_s;

  regfile_wr_arbiter #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_ready(r0), .req0_sel(s0), .req0_data(d0),
    .req1_valid(v1), .req1_ready(r1), .req1_sel(s1), .req1_data(d1),
    .rd_sel1(rd_sel1), .rd_sel2(rd_sel2),
    .rf_wr(rf_wr), .rf_seti(rf_seti), .rf_input(rf_input),
    .rf_seto1(seto1), .rf_seto2(seto2), .rf_out1(rf_out1), .rf_out2(rf_out2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .conflict_cnt(cnt)
  );

  regfile_wr_arbiter #(.DW(DW), .CW(2)) dut_small (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_ready(r0_s), .req0_sel(s0), .req0_data(d0),
    .req1_valid(v1), .req1_ready(r1_s), .req1_sel(s1), .req1_data(d1),
    .rd_sel1(rd_sel1), .rd_sel2(rd_sel2),
    .rf_wr(wr_s), .rf_seti(seti_s), .rf_input(input_s),
    .rf_seto1(seto1_s), .rf_seto2(seto2_s), .rf_out1(rf_out1), .rf_out2(rf_out2),
    .rd_data1(rdd1_s), .rd_data2(rdd2_s), .conflict_cnt(cnt_s)
  );

  // Register file driven by the main instance.
  logic [DW-1:0] rf_mem [2] = '{32'h0, 32'h0};
  always @(posedge clk) if (rf_wr) rf_mem[rf_seti] <= rf_input;
  assign rf_out1 = rf_mem[seto1];
  assign rf_out2 = rf_mem[seto2];

  // Reference model state
  int            total = 0;
  int            bad = 0;
  logic          prio_m;
  int            cnt_m, cnt_s_m;
  logic          exp_wr, exp_seti;
  logic [DW-1:0] exp_input;
  logic [DW-1:0] exp_reg [2] = '{32'h0, 32'h0};
  logic          g0, g1;

  function automatic void pred(output logic p0, output logic p1);
    p0 = reset && v0 && (!v1 || !prio_m);
    p1 = reset && v1 && (!v0 || prio_m);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic sel);
`ifdef RFARB_BYPASS_EN
    if (exp_wr && exp_seti == sel) return exp_input;
`endif
    return exp_reg[sel];
  endfunction

  task automatic clear_model();
    exp_wr = 1'b0; exp_seti = 1'b0; exp_input = '0;
    cnt_m = 0; cnt_s_m = 0; prio_m = 1'b0;
  endtask

  task automatic tick();
    logic p0, p1;
    pred(p0, p1);
    @(posedge clk);
    if (exp_wr) exp_reg[exp_seti] = exp_input;
    if (p0) begin
      exp_wr = 1'b1; exp_seti = s0; exp_input = d0;
    end else if (p1) begin
      exp_wr = 1'b1; exp_seti = s1; exp_input = d1;
    end else begin
      exp_wr = 1'b0;
    end
    if (reset && v0 && v1) begin
      prio_m = ~prio_m;
      if (cnt_m < 255) cnt_m++;
      if (cnt_s_m < 3) cnt_s_m++;
    end
    g0 = p0; g1 = p1;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_model();
    #2 reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; v0 = 0; v1 = 0; s0 = 0; s1 = 0; d0 = '0; d1 = '0;
    rd_sel1 = 0; rd_sel2 = 0;
    clear_model();
    @(posedge clk); #1;
    total++;
    if ({rf_wr, rf_seti, rf_input, cnt} !== '0) begin
      bad++; $display("FAIL reset_state got wr=%0b seti=%0b in=%h cnt=%0d exp all 0", rf_wr, rf_seti, rf_input, cnt);
    end
    reset = 1'b1;
    v0 = 1; v1 = 1; s0 = 1; s1 = 0; d0 = 32'h1234_5678; d1 = 32'h8765_4321;
    #1;
    repeat (3) tick();
    #2 reset = 1'b0;
    clear_model();
    #1;
    total++;
    if ({rf_wr, rf_input, cnt, cnt_s, r0, r1} !== '0) begin
      bad++; $display("FAIL mid_reset got wr=%0b in=%h cnt=%0d cnt_s=%0d rdy=%0b%0b exp all 0", rf_wr, rf_input, cnt, cnt_s, r0, r1);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if ({r0, r1} !== 2'b10) begin
      bad++; $display("FAIL post_reset_grant got rdy=%0b%0b exp 10", r0, r1);
    end
    tick();
    total++;
    if ({rf_wr, rf_seti, rf_input} !== {1'b1, 1'b1, 32'h1234_5678}) begin
      bad++; $display("FAIL post_reset_write got wr=%0b seti=%0b in=%h exp 1 1 12345678", rf_wr, rf_seti, rf_input);
    end
    v0 = 0; v1 = 0;
  endtask

  task automatic test_single();
    do_reset();
    v0 = 1; s0 = 1; d0 = 32'hDEAD_BEEF; v1 = 0; rd_sel1 = 1;
    #1;
    total++;
    if ({r0, r1} !== 2'b10) begin
      bad++; $display("FAIL single_ready got rdy=%0b%0b exp 10", r0, r1);
    end
    tick();
    v0 = 0;
    #1;
    total++;
    if ({rf_wr, rf_seti, rf_input} !== {1'b1, 1'b1, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL single_issue got wr=%0b seti=%0b in=%h exp 1 1 deadbeef", rf_wr, rf_seti, rf_input);
    end
    tick();
    total++;
    if ({rf_wr, rd_data1} !== {1'b0, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL single_read got wr=%0b rd1=%h exp 0 deadbeef", rf_wr, rd_data1);
    end
  endtask

  task automatic test_conflict();
    logic [1:0]    exp_rdy [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    logic [DW-1:0] exp_in  [4] = '{32'h1, 32'hA, 32'h2, 32'hB};
    do_reset();
    v0 = 1; v1 = 1; s0 = 0; s1 = 1; d0 = 32'h1; d1 = 32'hA;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if ({r0, r1} !== exp_rdy[i]) begin
        bad++; $display("FAIL conflict_grant[%0d] got rdy=%0b%0b exp %b", i, r0, r1, exp_rdy[i]);
      end
      tick();
      total++;
      if ({rf_wr, rf_input} !== {1'b1, exp_in[i]}) begin
        bad++; $display("FAIL conflict_input[%0d] got wr=%0b in=%h exp 1 %h", i, rf_wr, rf_input, exp_in[i]);
      end
      if (g0) d0 = d0 + 1; else d1 = d1 + 1;
    end
    total++;
    if (cnt !== 8'd4) begin
      bad++; $display("FAIL conflict_cnt got %0d exp 4", cnt);
    end
    v0 = 0; v1 = 0;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_c [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    do_reset();
    v0 = 1; v1 = 1; s0 = 0; s1 = 1; d0 = 32'h5; d1 = 32'h6;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (cnt_s !== exp_c[i] || cnt !== 8'(i + 1)) begin
        bad++; $display("FAIL sat_cnt[%0d] got small=%0d wide=%0d exp %0d %0d", i, cnt_s, cnt, exp_c[i], i + 1);
      end
    end
    v0 = 0; v1 = 0;
  endtask

  task automatic test_same_dest();
    do_reset();
    rd_sel1 = 0;
    v0 = 1; s0 = 0; d0 = 32'h11; v1 = 0;
    #1;
    tick();
    v0 = 0; v1 = 1; s1 = 0; d1 = 32'h22;
    #1;
    total++;
    if ({r1, rf_wr, rf_input} !== {1'b1, 1'b1, 32'h11}) begin
      bad++; $display("FAIL same_first got rdy1=%0b wr=%0b in=%h exp 1 1 11", r1, rf_wr, rf_input);
    end
    tick();
    v1 = 0;
    #1;
    total++;
    if ({rf_wr, rf_seti, rf_input} !== {1'b1, 1'b0, 32'h22}) begin
      bad++; $display("FAIL same_second got wr=%0b seti=%0b in=%h exp 1 0 22", rf_wr, rf_seti, rf_input);
    end
    tick();
    total++;
    if ({rf_wr, rd_data1} !== {1'b0, 32'h22}) begin
      bad++; $display("FAIL same_final got wr=%0b rd1=%h exp 0 22", rf_wr, rd_data1);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] old, want;
    do_reset();
    old = exp_reg[1];
    v0 = 1; s0 = 1; d0 = 32'h55; v1 = 0; rd_sel2 = 1;
    #1;
    tick();
    v0 = 0;
    #1;
`ifdef RFARB_BYPASS_EN
    want = 32'h55;
`else
    want = old;
`endif
    total++;
    if (rd_data2 !== want || old === 32'h55) begin
      bad++; $display("FAIL bypass_cycle got rd2=%h exp %h (old %h)", rd_data2, want, old);
    end
    tick();
    total++;
    if (rd_data2 !== 32'h55) begin
      bad++; $display("FAIL bypass_after got rd2=%h exp 55", rd_data2);
    end
  endtask

  task automatic test_random();
    logic p0, p1, pend0, pend1;
    do_reset();
    pend0 = 0; pend1 = 0;
    for (int i = 0; i < 300; i++) begin
      if (!pend0) begin
        v0 = 1'($urandom_range(0, 1)); s0 = 1'($urandom_range(0, 1)); d0 = $urandom();
      end
      if (!pend1) begin
        v1 = 1'($urandom_range(0, 1)); s1 = 1'($urandom_range(0, 1)); d1 = $urandom();
      end
      rd_sel1 = 1'($urandom_range(0, 1)); rd_sel2 = 1'($urandom_range(0, 1));
      #1;
      pred(p0, p1);
      total++;
      if ({r0, r1, r0_s, r1_s, seto1, seto2, seto1_s, seto2_s} !== {p0, p1, p0, p1, rd_sel1, rd_sel2, rd_sel1, rd_sel2}) begin
        bad++; $display("FAIL rand_ready[%0d] got rdy=%0b%0b small=%0b%0b seto=%0b%0b exp %0b%0b", i, r0, r1, r0_s, r1_s, seto1, seto2, p0, p1);
      end
      tick();
      pend0 = v0 && !g0;
      pend1 = v1 && !g1;
      total++;
      if ({rf_wr, rf_seti, rf_input, wr_s, seti_s, input_s} !== {exp_wr, exp_seti, exp_input, exp_wr, exp_seti, exp_input}) begin
        bad++; $display("FAIL rand_write[%0d] got wr=%0b seti=%0b in=%h exp %0b %0b %h", i, rf_wr, rf_seti, rf_input, exp_wr, exp_seti, exp_input);
      end
      total++;
      if (cnt !== 8'(cnt_m) || cnt_s !== 2'(cnt_s_m)) begin
        bad++; $display("FAIL rand_cnt[%0d] got %0d/%0d exp %0d/%0d", i, cnt, cnt_s, cnt_m, cnt_s_m);
      end
      total++;
      if ({rd_data1, rd_data2, rdd1_s, rdd2_s} !== {exp_rd(rd_sel1), exp_rd(rd_sel2), exp_rd(rd_sel1), exp_rd(rd_sel2)}) begin
        bad++; $display("FAIL rand_read[%0d] got %h %h exp %h %h", i, rd_data1, rd_data2, exp_rd(rd_sel1), exp_rd(rd_sel2));
      end
    end
    v0 = 0; v1 = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_conflict();
    test_saturation();
    test_same_dest();
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
